// File: rtl/cis_dvp_tx.sv
// cis_dvp_tx
//   Parallel camera (DVP-style) transmitter. Generates pclk_o, vsync_o, href_o
//   and data_o frames from either an incoming pixel stream or an internal ramp
//   (x + y) pattern. Used to loop back into the CIS receive path and to drive
//   external display bridges.
//
// Ports
//   wb_clk_i      in   system clock, only clock in the block
//   wb_rst_i      in   synchronous active-high reset
//   start_i       in   level, high = keep transmitting frames
//   mode_i        in   0 = stream source, 1 = ramp; latched at frame start
//   pix_data_i    in   stream pixel
//   pix_valid_i   in   stream pixel valid
//   pix_ready_o   out  stream pixel taken this cycle (valid && ready)
//   pclk_o        out  free-running pixel clock, period 2*PCLK_DIV
//   vsync_o       out  frame sync, active-high
//   href_o        out  line valid during active pixels
//   data_o        out  pixel data (0 outside active pixels)
//   frame_done_o  out  one-cycle pulse at end of each frame
//   busy_o        out  frame in progress
//   underrun_o    out  sticky, stream pixel missing at an active pixel
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | not transmitting, video outputs held at 0
// ST_VSYNC  | last launched tick is in a vsync line (vsync_o high)
// ST_VBACK  | last launched tick is in a back-porch blank line
// ST_ACTIVE | last launched tick is in an active line
// ST_VFRONT | last launched tick is in a front-porch blank line
module cis_dvp_tx #(
   parameter int DATA_W      = 10,
   parameter int PCLK_DIV    = 2,
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 160,
   parameter int VSYNC_LINES = 2,
   parameter int V_BACK      = 10,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start_i,
   input  logic              mode_i,
   input  logic [DATA_W-1:0] pix_data_i,
   input  logic              pix_valid_i,
   output logic              pix_ready_o,
   output logic              pclk_o,
   output logic              vsync_o,
   output logic              href_o,
   output logic [DATA_W-1:0] data_o,
   output logic              frame_done_o,
   output logic              busy_o,
   output logic              underrun_o
);

   localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL   = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int V_ACT_BEG = VSYNC_LINES + V_BACK;
   localparam int V_ACT_END = V_ACT_BEG + V_ACTIVE;
   localparam int DIV_TOTAL = 2 * PCLK_DIV;
   localparam int DW        = ($clog2(DIV_TOTAL) > 0) ? $clog2(DIV_TOTAL) : 1;
   localparam int HW        = ($clog2(H_TOTAL) > 0) ? $clog2(H_TOTAL) : 1;
   localparam int VW        = ($clog2(V_TOTAL) > 0) ? $clog2(V_TOTAL) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_TOTAL - 1);
   localparam logic [DW-1:0] DIV_HALF  = DW'(PCLK_DIV);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VS_END  = VW'(VSYNC_LINES);
   localparam logic [VW-1:0] V_ACT_B_C = VW'(V_ACT_BEG);
   localparam logic [VW-1:0] V_ACT_E_C = VW'(V_ACT_END);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_VSYNC  = 3'd1;
   localparam logic [2:0] ST_VBACK  = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_VFRONT = 3'd4;

   // h_cnt/v_cnt point at the next tick to be launched, so everything that
   // goes out on a launch edge is decoded straight from the current counts.
   logic [DW-1:0]     div_cnt;
   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic [2:0]        state;
   logic [2:0]        tick_st;
   logic              mode_q;
   logic              launch;
   logic              at_origin;
   logic              emit;
   logic              pix_act;
   logic [DATA_W-1:0] ramp_pix;

   always_comb begin
      tick_st = ST_VFRONT;
      if (v_cnt < V_VS_END)
         tick_st = ST_VSYNC;
      else if (v_cnt < V_ACT_B_C)
         tick_st = ST_VBACK;
      else if (v_cnt < V_ACT_E_C)
         tick_st = ST_ACTIVE;
   end

   assign launch    = (div_cnt == DIV_LAST);
   assign at_origin = (h_cnt == '0) && (v_cnt == '0);
   // Counters sit at the origin both in IDLE and right after the last tick of
   // a frame; there start_i decides whether another frame begins.
   assign emit      = launch && (start_i || ((state != ST_IDLE) && !at_origin));
   assign pix_act   = (tick_st == ST_ACTIVE) && (h_cnt < H_ACT_C);
   assign ramp_pix  = DATA_W'(h_cnt) + DATA_W'(v_cnt - V_ACT_B_C);

   // The origin tick is a vsync tick, so mode_q is always the latched mode
   // whenever pix_act is true.
   assign pix_ready_o = emit && pix_act && !mode_q && !wb_rst_i;
   assign pclk_o      = (div_cnt >= DIV_HALF);
   assign busy_o      = (state != ST_IDLE);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         div_cnt      <= '0;
         h_cnt        <= '0;
         v_cnt        <= '0;
         state        <= ST_IDLE;
         mode_q       <= 1'b0;
         vsync_o      <= 1'b0;
         href_o       <= 1'b0;
         data_o       <= '0;
         frame_done_o <= 1'b0;
         underrun_o   <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         div_cnt      <= launch ? '0 : div_cnt + 1'b1;
         if (launch) begin
            frame_done_o <= (state != ST_IDLE) && at_origin;
            state        <= emit ? tick_st : ST_IDLE;
            if (emit) begin
               if (at_origin) begin
                  mode_q <= mode_i;
                  if (state == ST_IDLE)
                     underrun_o <= 1'b0;
               end
               if (h_cnt == H_LAST) begin
                  h_cnt <= '0;
                  v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
               vsync_o <= (tick_st == ST_VSYNC);
               href_o  <= pix_act;
               if (!pix_act)
                  data_o <= '0;
               else if (mode_q)
                  data_o <= ramp_pix;
               else if (pix_valid_i)
                  data_o <= pix_data_i;
               else begin
                  // Missing pixel: send 0, keep line timing, flag it.
                  data_o     <= '0;
                  underrun_o <= 1'b1;
               end
            end else begin
               vsync_o <= 1'b0;
               href_o  <= 1'b0;
               data_o  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cis_dvp_tx.sv
module tb_cis_dvp_tx;

   localparam int TICKS = 30;   // 6 ticks/line x 5 lines

   typedef struct packed {
      logic       vs;
      logic       hr;
      logic [9:0] d;
      logic       strm;
      logic       fd;
      logic       busy;
      logic       fresh;
   } tick_t;

   logic       wb_clk_i, wb_rst_i, start_i, mode_i, pix_valid_i;
   logic [9:0] pix_data_i;
   logic       pix_ready_o, pclk_o, vsync_o, href_o, frame_done_o, busy_o, underrun_o;
   logic [9:0] data_o;

   cis_dvp_tx #(
      .DATA_W(10), .PCLK_DIV(2), .H_ACTIVE(4), .H_BLANK(2),
      .VSYNC_LINES(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .mode_i(mode_i),
      .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .pclk_o(pclk_o), .vsync_o(vsync_o), .href_o(href_o), .data_o(data_o),
      .frame_done_o(frame_done_o), .busy_o(busy_o), .underrun_o(underrun_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   tick_t      exp_q[$];
   logic [9:0] sdat_q[$];
   int         vs_rise_q[$];
   int         n_tests = 0, n_fail = 0;
   int         cyc = 0, vs_hi = 0, hr_hi = 0, fd_cyc = 0, busy_cyc = 0;
   int         sidx = 0, n_hs = 0, px_cnt = 0, drop_at = -1;
   logic       src_valid = 1'b0, exp_ur = 1'b0;
   logic       pclk_prev = 1'b0, vs_prev = 1'b0, hr_prev = 1'b0, busy_prev = 1'b0;
   logic [9:0] d_prev = '0;

   function automatic logic [9:0] sval(input int i);
      return (i == 0) ? 10'h3FF : 10'(i);
   endfunction

   task automatic push_frame(input logic strm, input logic chained);
      tick_t e;
      for (int t = 0; t < TICKS; t++) begin
         int h, v;
         logic act;
         h = t % 6;
         v = t / 6;
         act     = (v >= 2) && (v < 4) && (h < 4);
         e       = '0;
         e.vs    = (v < 1);
         e.hr    = act;
         e.d     = act ? 10'(h + v - 2) : 10'd0;
         e.strm  = strm && act;
         e.fd    = (t == 0) && chained;
         e.busy  = 1'b1;
         e.fresh = (t == 0) && !chained;
         exp_q.push_back(e);
      end
   endtask

   task automatic push_end();
      tick_t e;
      e    = '0;
      e.fd = 1'b1;
      exp_q.push_back(e);
   endtask

   // One clock: observe at the falling clock edge, score launched ticks,
   // then feed the stream source for the coming rising edge.
   task automatic step();
      tick_t      e;
      logic [9:0] ed;
      logic       launch;
      @(negedge wb_clk_i);
      cyc++;
      launch = pclk_prev && !pclk_o;
      if (launch) begin
         e = '0;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         if (e.fresh) exp_ur = 1'b0;
         ed = e.d;
         if (e.strm) begin
            if (sdat_q.size() > 0) ed = sdat_q.pop_front();
            else begin
               ed = '0;
               n_tests++; n_fail++;
               $display("FAIL stream_q_empty cyc=%0d: active stream tick with no pixel offered", cyc);
            end
         end
         n_tests++;
         if (vsync_o !== e.vs || href_o !== e.hr || data_o !== ed ||
             frame_done_o !== e.fd || busy_o !== e.busy) begin
            n_fail++;
            $display("FAIL tick cyc=%0d got vs=%b hr=%b d=%h fd=%b busy=%b, want vs=%b hr=%b d=%h fd=%b busy=%b",
                     cyc, vsync_o, href_o, data_o, frame_done_o, busy_o, e.vs, e.hr, ed, e.fd, e.busy);
         end
         if (e.busy) begin
            n_tests++;
            if (underrun_o !== exp_ur) begin
               n_fail++;
               $display("FAIL underrun cyc=%0d got %b want %b", cyc, underrun_o, exp_ur);
            end
         end
      end else begin
         n_tests++;
         if (frame_done_o !== 1'b0 || vsync_o !== vs_prev || href_o !== hr_prev || data_o !== d_prev) begin
            n_fail++;
            $display("FAIL hold cyc=%0d pclk=%b got vs=%b hr=%b d=%h fd=%b, want vs=%b hr=%b d=%h fd=0",
                     cyc, pclk_o, vsync_o, href_o, data_o, frame_done_o, vs_prev, hr_prev, d_prev);
         end
      end
      if (vsync_o && !vs_prev) vs_rise_q.push_back(cyc);
      if (vsync_o) vs_hi++;
      if (href_o) hr_hi++;
      if (frame_done_o) fd_cyc = cyc;
      if (busy_o && !busy_prev) busy_cyc = cyc;
      pclk_prev = pclk_o; vs_prev = vsync_o; hr_prev = href_o; d_prev = data_o; busy_prev = busy_o;
      pix_valid_i = src_valid;
      pix_data_i  = sval(sidx);
      if (pix_ready_o) begin
         if (px_cnt == drop_at) begin
            pix_valid_i = 1'b0;
            exp_ur      = 1'b1;
         end
         if (pix_valid_i) begin
            sdat_q.push_back(pix_data_i);
            sidx++;
            n_hs++;
         end else begin
            sdat_q.push_back(10'd0);
         end
         px_cnt++;
      end
   endtask

   task automatic start_frame();
      int k;
      start_i = 1'b1;
      k = 0;
      while (!busy_o && k < 12) begin step(); k++; end
      n_tests++;
      if (busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL start_timeout busy=%b want 1", busy_o);
      end
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() > 0 && k < budget) begin step(); k++; end
      n_tests++;
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (8) step();
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      n_tests++;
      if ({pclk_o, vsync_o, href_o, data_o, frame_done_o, busy_o, underrun_o, pix_ready_o} !== 17'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got pclk=%b vs=%b hr=%b d=%h fd=%b busy=%b ur=%b rdy=%b want all 0",
                  pclk_o, vsync_o, href_o, data_o, frame_done_o, busy_o, underrun_o, pix_ready_o);
      end
      wb_rst_i = 1'b0;
      repeat (12) step();   // idle launches scored as all-zero
   endtask

   task automatic test_one_shot();
      mode_i = 1'b1; src_valid = 1'b0; n_hs = 0; vs_hi = 0; hr_hi = 0;
      push_frame(1'b0, 1'b0);
      push_end();
      start_frame();
      start_i = 1'b0;
      drain(200);
      n_tests++;
      if (vs_hi != 24) begin n_fail++; $display("FAIL vsync_width got %0d want 24", vs_hi); end
      n_tests++;
      if (hr_hi != 32) begin n_fail++; $display("FAIL href_width got %0d want 32", hr_hi); end
      n_tests++;
      if (fd_cyc - busy_cyc != 120) begin
         n_fail++; $display("FAIL frame_len got %0d want 120", fd_cyc - busy_cyc);
      end
      n_tests++;
      if (n_hs != 0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL ramp_idle got hs=%0d busy=%b want 0 0", n_hs, busy_o);
      end
   endtask

   task automatic test_stream();
      mode_i = 1'b0; src_valid = 1'b1; sidx = 0; n_hs = 0; px_cnt = 0; drop_at = -1;
      push_frame(1'b1, 1'b0);
      push_end();
      start_frame();
      start_i = 1'b0;
      drain(200);
      n_tests++;
      if (n_hs != 8 || sdat_q.size() != 0) begin
         n_fail++; $display("FAIL stream_hs got %0d left=%0d want 8 0", n_hs, sdat_q.size());
      end
   endtask

   task automatic test_underrun();
      int k;
      mode_i = 1'b0; src_valid = 1'b1; sidx = 0; n_hs = 0; px_cnt = 0; drop_at = 2;
      push_frame(1'b1, 1'b0);
      push_frame(1'b1, 1'b1);
      push_end();
      start_frame();
      k = 0;
      while (exp_q.size() > 20 && k < 300) begin step(); k++; end
      start_i = 1'b0;
      drain(200);
      drop_at = -1;
      n_tests++;
      if (n_hs != 15) begin n_fail++; $display("FAIL underrun_hs got %0d want 15", n_hs); end
   endtask

   task automatic test_back_to_back();
      int k;
      mode_i = 1'b1; src_valid = 1'b1; sidx = 0; n_hs = 0; px_cnt = 0;
      vs_rise_q.delete();
      push_frame(1'b0, 1'b0);
      push_frame(1'b1, 1'b1);
      push_frame(1'b0, 1'b1);
      push_end();
      start_frame();
      mode_i = 1'b0;      // ignored in frame 1, latched for frame 2
      k = 0;
      while (exp_q.size() > 60 && k < 300) begin step(); k++; end
      mode_i = 1'b1;      // latched for frame 3
      k = 0;
      while (exp_q.size() > 21 && k < 300) begin step(); k++; end
      start_i = 1'b0;
      drain(300);
      n_tests++;
      if (vs_rise_q.size() != 3) begin
         n_fail++; $display("FAIL vsync_count got %0d want 3", vs_rise_q.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_tests++;
            if (vs_rise_q[i] - vs_rise_q[i-1] != 120) begin
               n_fail++;
               $display("FAIL frame_period got %0d want 120", vs_rise_q[i] - vs_rise_q[i-1]);
            end
         end
      end
      n_tests++;
      if (n_hs != 8) begin n_fail++; $display("FAIL b2b_hs got %0d want 8", n_hs); end
   endtask

   task automatic test_mid_reset();
      int k;
      mode_i = 1'b1; src_valid = 1'b0;
      push_frame(1'b0, 1'b0);
      push_end();
      start_frame();
      start_i = 1'b0;
      k = 0;
      while (exp_q.size() > 10 && k < 200) begin step(); k++; end
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      cyc++;
      n_tests++;
      if ({pclk_o, vsync_o, href_o, data_o, frame_done_o, busy_o, underrun_o, pix_ready_o} !== 17'd0) begin
         n_fail++;
         $display("FAIL midreset got pclk=%b vs=%b hr=%b d=%h fd=%b busy=%b ur=%b rdy=%b want all 0",
                  pclk_o, vsync_o, href_o, data_o, frame_done_o, busy_o, underrun_o, pix_ready_o);
      end
      exp_q.delete();
      sdat_q.delete();
      pclk_prev = 1'b0; vs_prev = 1'b0; hr_prev = 1'b0; d_prev = '0; busy_prev = 1'b0;
      repeat (6) step();
      push_frame(1'b0, 1'b0);
      push_end();
      start_frame();
      start_i = 1'b0;
      drain(200);
      n_tests++;
      if (fd_cyc - busy_cyc != 120) begin
         n_fail++; $display("FAIL restart_len got %0d want 120", fd_cyc - busy_cyc);
      end
   endtask

   task automatic test_mode_ignore();
      int k, last_rise, nper;
      logic pl_prev;
      mode_i = 1'b1; src_valid = 1'b1; n_hs = 0;
      push_frame(1'b0, 1'b0);
      push_end();
      start_frame();
      start_i = 1'b0;
      last_rise = -1; nper = 0; pl_prev = pclk_o; k = 0;
      while (exp_q.size() > 0 && k < 200) begin
         if (k % 5 == 0) mode_i = ~mode_i;
         step();
         if (pclk_o && !pl_prev) begin
            if (last_rise >= 0 && nper < 8) begin
               nper++;
               n_tests++;
               if (cyc - last_rise != 4) begin
                  n_fail++; $display("FAIL pclk_period got %0d want 4", cyc - last_rise);
               end
            end
            last_rise = cyc;
         end
         pl_prev = pclk_o;
         k++;
      end
      drain(20);
      n_tests++;
      if (n_hs != 0) begin n_fail++; $display("FAIL mode_ignore_hs got %0d want 0", n_hs); end
   endtask

   initial begin
      wb_rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
      pix_data_i = '0; pix_valid_i = 1'b0;
      test_reset();
      test_one_shot();
      test_stream();
      test_underrun();
      test_back_to_back();
      test_mid_reset();
      test_mode_ignore();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
